ipsxe_floating_point_mant_sqrt_v1_0: RTL

Iterative restoring square-root core for the normalised significand.
- Sits directly downstream of the exponent square-root stage. Consumes that stage's halved, re-biased exponent plus the parity of the unbiased exponent and the fraction field.
- Produces the rounded result fraction and aligned exponent, one result bit per cycle, with valid/ready handshakes on both sides.
- Special operands (zero, inf, NaN, negative) are bypassed upstream; this core sees only normal positive operands.

---
 rtl/ipsxe_floating_point_mant_sqrt_v1_0_pkg.sv | 24 ++
 rtl/ipsxe_floating_point_sqrt_round_v1_0.sv | 29 ++
 rtl/ipsxe_floating_point_mant_sqrt_v1_0.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ipsxe_floating_point_mant_sqrt_v1_0_pkg.sv
// Shared definitions for the significand square-root core: FSM encoding,
// IEEE single/double field widths and the exponent bias used by the exponent stage.
package ipsxe_floating_point_mant_sqrt_v1_0_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } sqrt_state_t;

    localparam int SP_EXPONENT_SIZE = 8;
    localparam int SP_FRACTION_SIZE = 23;
    localparam int DP_EXPONENT_SIZE = 11;
    localparam int DP_FRACTION_SIZE = 52;

    function automatic int exp_bias(input int exp_size);
        return (1 << (exp_size - 1)) - 1;
    endfunction

    localparam int SP_EXP_BIAS = exp_bias(SP_EXPONENT_SIZE);
    localparam int DP_EXP_BIAS = exp_bias(DP_EXPONENT_SIZE);

endpackage

// File: rtl/ipsxe_floating_point_sqrt_round_v1_0.sv
// Combinational rounding of the raw root: takes root bits [F:0] (fraction plus
// round bit) and the final remainder, yields the stored fraction and inexact flag.
module ipsxe_floating_point_sqrt_round_v1_0
    import ipsxe_floating_point_mant_sqrt_v1_0_pkg::*;
#(
    parameter int FRACTION_SIZE = DP_FRACTION_SIZE
) (
    input  logic [FRACTION_SIZE:0]   i_root,
    input  logic [FRACTION_SIZE+3:0] i_rem,
    input  logic                     i_rne,
    output logic [FRACTION_SIZE-1:0] o_fraction,
    output logic                     o_inexact
);

    localparam int F = FRACTION_SIZE;

    logic round_bit;
    logic sticky;

    always_comb begin
        round_bit = i_root[0];
        sticky    = |i_rem;
        // A sqrt result can never sit exactly halfway, so nearest needs no tie logic
        // and the increment cannot carry past the hidden bit.
        o_fraction = i_root[F:1] + {{(F-1){1'b0}}, (i_rne & round_bit)};
        o_inexact  = round_bit | sticky;
    end

endmodule

// File: rtl/ipsxe_floating_point_mant_sqrt_v1_0.sv
// Iterative restoring square root of the normalised significand, one root bit per
// cycle. Define IPSXE_FLT_SQRT_RNE_EN for round-to-nearest, otherwise truncation.
module ipsxe_floating_point_mant_sqrt_v1_0
    import ipsxe_floating_point_mant_sqrt_v1_0_pkg::*;
#(
    parameter int EXPONENT_SIZE = DP_EXPONENT_SIZE,
    parameter int FRACTION_SIZE = DP_FRACTION_SIZE
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [FRACTION_SIZE-1:0] i_fraction,
    input  logic                     i_exp_odd,
    input  logic [EXPONENT_SIZE-1:0] i_exp_sqrt,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [FRACTION_SIZE-1:0] o_fraction,
    output logic [EXPONENT_SIZE-1:0] o_exponent,
    output logic                     o_inexact
);

    localparam int F  = FRACTION_SIZE;
    localparam int E  = EXPONENT_SIZE;
    localparam int CW = $clog2(F + 2);

`ifdef IPSXE_FLT_SQRT_RNE_EN
    localparam logic RNE_MODE = 1'b1;
`else
    localparam logic RNE_MODE = 1'b0;
`endif

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and a result is held until it transfers.
    sqrt_state_t     state_q, state_d;
    logic [F+2:0]    rad_q, rad_d;
    logic [F+1:0]    root_q, root_d;
    logic [F+3:0]    rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [E-1:0]    exp_q, exp_d;
    logic [F-1:0]    frac_out_q, frac_out_d;
    logic [E-1:0]    exp_out_q, exp_out_d;
    logic            inexact_q, inexact_d;

    logic [F+5:0]    step_wide;
    logic [F+5:0]    step_sub;
    logic [F+5:0]    step_diff;
    logic            step_ge;
    logic [F-1:0]    rnd_fraction;
    logic            rnd_inexact;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            rad_q      <= '0;
            root_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            exp_q      <= '0;
            frac_out_q <= '0;
            exp_out_q  <= '0;
            inexact_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rad_q      <= rad_d;
            root_q     <= root_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            frac_out_q <= frac_out_d;
            exp_out_q  <= exp_out_d;
            inexact_q  <= inexact_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_valid) state_d = ST_CALC;
            ST_CALC:  if (cnt_q == '0) state_d = ST_ROUND;
            ST_ROUND: state_d = ST_DONE;
            ST_DONE:  if (i_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready    = (state_q == ST_IDLE);
        o_valid    = (state_q == ST_DONE);
        o_fraction = frac_out_q;
        o_exponent = exp_out_q;
        o_inexact  = inexact_q;
    end

    // Restoring step: bring down the next radicand pair and try subtracting 4*root+1.
    always_comb begin
        step_wide = {rem_q, rad_q[F+2:F+1]};
        step_sub  = {2'b00, root_q, 2'b01};
        step_ge   = (step_wide >= step_sub);
        step_diff = step_wide - step_sub;
    end

    always_comb begin
        rad_d      = rad_q;
        root_d     = root_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        frac_out_d = frac_out_q;
        exp_out_d  = exp_out_q;
        inexact_d  = inexact_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    // Odd unbiased exponent: significand is doubled so the root stays in [1,2).
                    rad_d  = i_exp_odd ? {1'b1, i_fraction, 2'b00} : {2'b01, i_fraction, 1'b0};
                    exp_d  = i_exp_sqrt;
                    root_d = '0;
                    rem_d  = '0;
                    cnt_d  = CW'(F + 1);
                end
            end
            ST_CALC: begin
                rad_d  = {rad_q[F:0], 2'b00};
                root_d = {root_q[F:0], step_ge};
                rem_d  = step_ge ? step_diff[F+3:0] : step_wide[F+3:0];
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            ST_ROUND: begin
                frac_out_d = rnd_fraction;
                exp_out_d  = exp_q;
                inexact_d  = rnd_inexact;
            end
            default: begin
            end
        endcase
    end

    ipsxe_floating_point_sqrt_round_v1_0 #(
        .FRACTION_SIZE (F)
    ) u_round (
        .i_root     (root_q[F:0]),
        .i_rem      (rem_q),
        .i_rne      (RNE_MODE),
        .o_fraction (rnd_fraction),
        .o_inexact  (rnd_inexact)
    );

endmodule
